// File: rtl/eth_sw_downsizer.sv
// 128-to-64 bit egress width converter: framing checker, beat FIFO and a
// drain FSM that emits each buffered beat as one or two 64-bit words.
module eth_sw_downsizer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic                          data_valid,
    input  logic [127:0]                  data,
    input  logic [3:0]                    data_bytes,
    input  logic                          sof,
    input  logic                          eof,
    input  logic [9:0]                    block_tag,
    output logic                          in_ready,
    output logic                          sw_data_valid,
    output logic [63:0]                   sw_data,
    output logic [2:0]                    sw_data_bytes,
    output logic                          sw_sof,
    output logic                          sw_eof,
    output logic [9:0]                    sw_block_tag,
    output logic [ERR_W-1:0]              err_cnt,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   bytes;
        logic         sof;
        logic         eof;
        logic [9:0]   tag;
    } beat_t;

    typedef enum logic {OUT_PKT, IN_PKT} chk_t;
    typedef enum logic [1:0] {IDLE, UPPER, LOWER} drn_t;

    beat_t             mem [FIFO_DEPTH];
    beat_t             in_beat;
    beat_t             hold;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              fifo_empty;
    logic              push, pop, err_inc;
    chk_t              chk_q, chk_next;
    drn_t              drn_q, drn_next;
    logic              hold_short;

    logic              nxt_valid;
    logic [63:0]       nxt_data;
    logic [2:0]        nxt_bytes;
    logic              nxt_sof;
    logic              nxt_eof;
    logic [9:0]        nxt_tag;

    assign in_ready   = (fifo_level < LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign hold_short = hold.eof & ~hold.bytes[3];

    always_comb begin
        in_beat.data  = data;
        in_beat.bytes = data_bytes;
        in_beat.sof   = sof;
        in_beat.eof   = eof;
        in_beat.tag   = block_tag;
    end

    // Framing checker: decides which presented beats are written and which count as errors.
    always_comb begin
        push     = 1'b0;
        err_inc  = 1'b0;
        chk_next = chk_q;
        if (data_valid && !in_ready) begin
            err_inc = 1'b1;
        end else if (data_valid) begin
            case (chk_q)
                OUT_PKT: begin
                    if (sof) begin
                        push     = 1'b1;
                        chk_next = eof ? OUT_PKT : IN_PKT;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                IN_PKT: begin
                    push     = 1'b1;
                    err_inc  = sof;
                    chk_next = eof ? OUT_PKT : IN_PKT;
                end
                default: chk_next = OUT_PKT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            chk_q   <= OUT_PKT;
            err_cnt <= '0;
        end else begin
            chk_q <= chk_next;
            if (err_clr)
                err_cnt <= '0;
            else if (err_inc && (err_cnt != '1))
                err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    // Beat storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= in_beat;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            hold       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                hold   <= mem[rd_ptr];
            end
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            drn_q <= IDLE;
        else
            drn_q <= drn_next;
    end

    // Drain FSM next state and pop; a short eof beat skips the LOWER word.
    always_comb begin
        drn_next = drn_q;
        pop      = 1'b0;
        case (drn_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    drn_next = UPPER;
                end
            end
            UPPER: begin
                if (hold_short) begin
                    pop      = !fifo_empty;
                    drn_next = fifo_empty ? IDLE : UPPER;
                end else begin
                    drn_next = LOWER;
                end
            end
            LOWER: begin
                pop      = !fifo_empty;
                drn_next = fifo_empty ? IDLE : UPPER;
            end
            default: drn_next = IDLE;
        endcase
    end

    // Drain FSM output decode, registered below.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_data  = '0;
        nxt_bytes = '0;
        nxt_sof   = 1'b0;
        nxt_eof   = 1'b0;
        nxt_tag   = '0;
        case (drn_q)
            UPPER: begin
                nxt_valid = 1'b1;
                nxt_data  = hold.data[127:64];
                nxt_sof   = hold.sof;
                nxt_tag   = hold.tag;
                nxt_eof   = hold_short;
                nxt_bytes = hold_short ? hold.bytes[2:0] : 3'd7;
            end
            LOWER: begin
                nxt_valid = 1'b1;
                nxt_data  = hold.data[63:0];
                nxt_tag   = hold.tag;
                nxt_eof   = hold.eof;
                nxt_bytes = hold.eof ? hold.bytes[2:0] : 3'd7;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sw_data_valid <= 1'b0;
            sw_data       <= '0;
            sw_data_bytes <= '0;
            sw_sof        <= 1'b0;
            sw_eof        <= 1'b0;
            sw_block_tag  <= '0;
        end else begin
            sw_data_valid <= nxt_valid;
            sw_data       <= nxt_data;
            sw_data_bytes <= nxt_bytes;
            sw_sof        <= nxt_sof;
            sw_eof        <= nxt_eof;
            sw_block_tag  <= nxt_tag;
        end
    end

endmodule
